// File: rtl/regfile_pkg.sv
// Shared widths, write-request payload and grant encoding for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } rf_wr_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_AUX
    } grant_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/aux_write_fifo.sv
// Small FIFO for aux-unit register writes; exposes per-entry valid bits and
// destination registers so the parent can build the pending-write mask.
module aux_write_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push_i,
    input  rf_wr_req_t                            push_req_i,
    input  logic                                  pop_i,
    output logic                                  full_c_o,
    output logic                                  empty_c_o,
    output rf_wr_req_t                            head_c_o,
    output logic [DEPTH-1:0]                      entry_vld_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_reg_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    rf_wr_req_t       mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_c_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_c_o   = (cnt_q == '0);
    assign push_ok     = push_i && !full_c_o;
    assign pop_ok      = pop_i && !empty_c_o;
    assign head_c_o    = mem_q[rd_ptr_q];
    assign entry_vld_o = vld_q;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_reg_o[i] = mem_q[i].reg_addr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; cnt tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        if (pop_ok) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset: entries are only observed through vld_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the pipeline
// writeback stage and a buffered aux unit, with WAW ordering and anti-starvation.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned AUX_DEPTH = 2,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_wr_en,
    input  logic [REG_ADDR_W-1:0]  pipe_wr_reg,
    input  logic [DATA_W-1:0]      pipe_wr_data,
    output logic                   pipe_stall,
    input  logic                   aux_valid,
    input  logic [REG_ADDR_W-1:0]  aux_reg,
    input  logic [DATA_W-1:0]      aux_data,
    output logic                   aux_ready,
    output logic                   rf_reg_write,
    output logic [REG_ADDR_W-1:0]  rf_write_reg,
    output logic [DATA_W-1:0]      rf_write_data,
    output logic [NUM_REGS-1:0]    pending_mask
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic                                 fifo_full;
    logic                                 fifo_empty;
    rf_wr_req_t                           fifo_head;
    logic [AUX_DEPTH-1:0]                 fifo_vld;
    logic [AUX_DEPTH-1:0][REG_ADDR_W-1:0] fifo_regs;
    logic                                 aux_push;
    logic                                 pipe_live;
    grant_t                               grant_c;

    logic              rdy_q;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    rf_wr_req_t        rf_req_q, rf_req_d;

    assign aux_ready = rdy_q && !fifo_full;
    assign aux_push  = aux_valid && aux_ready && (aux_reg != '0);
    assign pipe_live = pipe_wr_en && (pipe_wr_reg != '0);

    aux_write_fifo #(
        .DEPTH (AUX_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (aux_push),
        .push_req_i  ('{reg_addr: aux_reg, data: aux_data}),
        .pop_i       (grant_c == GRANT_AUX),
        .full_c_o    (fifo_full),
        .empty_c_o   (fifo_empty),
        .head_c_o    (fifo_head),
        .entry_vld_o (fifo_vld),
        .entry_reg_o (fifo_regs)
    );

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < AUX_DEPTH; i++) begin
            if (fifo_vld[i]) begin
                pending_mask = pending_mask | reg_onehot(fifo_regs[i]);
            end
        end
    end

    // Priority: starved aux head, WAW hazard drain, pipe, idle aux drain.
    always_comb begin
        grant_c    = GRANT_NONE;
        pipe_stall = 1'b0;
        if (!fifo_empty && (wait_cnt_q >= WAIT_W'(MAX_WAIT))) begin
            grant_c    = GRANT_AUX;
            pipe_stall = pipe_live;
        end else if (pipe_live && pending_mask[pipe_wr_reg]) begin
            grant_c    = GRANT_AUX;
            pipe_stall = 1'b1;
        end else if (pipe_live) begin
            grant_c = GRANT_PIPE;
        end else if (!fifo_empty) begin
            grant_c = GRANT_AUX;
        end
    end

    always_comb begin
        rf_we_d    = (grant_c != GRANT_NONE);
        rf_req_d   = rf_req_q;
        wait_cnt_d = '0;
        if (grant_c == GRANT_PIPE) begin
            rf_req_d = '{reg_addr: pipe_wr_reg, data: pipe_wr_data};
        end else if (grant_c == GRANT_AUX) begin
            rf_req_d = fifo_head;
        end
        if (!fifo_empty && (grant_c != GRANT_AUX)) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_req_q   <= '0;
        end else begin
            rdy_q      <= 1'b1;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_req_q   <= rf_req_d;
        end
    end

    assign rf_reg_write  = rf_we_q;
    assign rf_write_reg  = rf_req_q.reg_addr;
    assign rf_write_data = rf_req_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic        clk;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_reg;
    logic [31:0] pipe_wr_data;
    logic        pipe_stall;
    logic        aux_valid;
    logic [4:0]  aux_reg;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;

    regfile_write_arbiter #(
        .AUX_DEPTH (DEPTH),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_wr_en    (pipe_wr_en),
        .pipe_wr_reg   (pipe_wr_reg),
        .pipe_wr_data  (pipe_wr_data),
        .pipe_stall    (pipe_stall),
        .aux_valid     (aux_valid),
        .aux_reg       (aux_reg),
        .aux_data      (aux_data),
        .aux_ready     (aux_ready),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .pending_mask  (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queued aux writes, starvation counter, out-of-reset flag.
    logic [4:0]  q_reg [$];
    logic [31:0] q_dat [$];
    int          m_wait = 0;
    logic        m_up   = 1'b0;

    logic        obs_stall;
    logic        obs_rdy;
    logic [31:0] obs_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        pipe_wr_en   = 1'b0;
        pipe_wr_reg  = 5'd0;
        pipe_wr_data = 32'd0;
        aux_valid    = 1'b0;
        aux_reg      = 5'd0;
        aux_data     = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("rst_rf_write_reg", 32'(rf_write_reg), 32'd0);
        chk("rst_rf_write_data", rf_write_data, 32'd0);
        chk("rst_pending_mask", pending_mask, 32'd0);
        chk("rst_aux_ready", 32'(aux_ready), 32'd0);
        q_reg.delete();
        q_dat.delete();
        m_wait = 0;
        m_up   = 1'b0;
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        chk("rel_aux_ready_low", 32'(aux_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_aux_ready_high", 32'(aux_ready), 32'd1);
        chk("rel_rf_reg_write", 32'(rf_reg_write), 32'd0);
        m_up = 1'b1;
    endtask

    // One cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
        logic        rdy, live, stall, pop, take_pipe, ew;
        logic [31:0] mask;
        logic [4:0]  er;
        logic [31:0] ed;
        int          n;
        @(negedge clk);
        pipe_wr_en   = pe;
        pipe_wr_reg  = pr;
        pipe_wr_data = pd;
        aux_valid    = av;
        aux_reg      = ar;
        aux_data     = ad;
        #1;
        n    = q_reg.size();
        rdy  = m_up && (n < DEPTH);
        mask = 32'd0;
        foreach (q_reg[i]) mask[q_reg[i]] = 1'b1;
        live      = pe && (pr != 5'd0);
        pop       = 1'b0;
        take_pipe = 1'b0;
        stall     = 1'b0;
        if (n > 0 && m_wait >= MAXW) begin
            pop   = 1'b1;
            stall = live;
        end else if (live && mask[pr]) begin
            pop   = 1'b1;
            stall = 1'b1;
        end else if (live) begin
            take_pipe = 1'b1;
        end else if (n > 0) begin
            pop = 1'b1;
        end
        chk("aux_ready", 32'(aux_ready), 32'(rdy));
        chk("pipe_stall", 32'(pipe_stall), 32'(stall));
        chk("pending_mask", pending_mask, mask);
        obs_stall = pipe_stall;
        obs_rdy   = aux_ready;
        obs_mask  = pending_mask;
        ew = pop || take_pipe;
        er = pr;
        ed = pd;
        if (pop) begin
            er = q_reg.pop_front();
            ed = q_dat.pop_front();
            m_wait = 0;
        end else if (n > 0) begin
            m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
        end else begin
            m_wait = 0;
        end
        if (av && rdy && ar != 5'd0) begin
            q_reg.push_back(ar);
            q_dat.push_back(ad);
        end
        m_up = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_reg_write", 32'(rf_reg_write), 32'(ew));
        if (ew) begin
            chk("rf_write_reg", 32'(rf_write_reg), 32'(er));
            chk("rf_write_data", rf_write_data, ed);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        do_reset();

        // Pipe only.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("pipe_only_stall", 32'(obs_stall), 32'd0);
        chk("pipe_only_we", 32'(rf_reg_write), 32'd1);
        chk("pipe_only_reg", 32'(rf_write_reg), 32'd5);
        chk("pipe_only_data", rf_write_data, 32'hDEADBEEF);

        // Aux on an idle port.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        chk("aux_idle_no_write", 32'(rf_reg_write), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("aux_idle_mask", obs_mask, 32'h80);
        chk("aux_idle_reg", 32'(rf_write_reg), 32'd7);
        chk("aux_idle_data", rf_write_data, 32'h11);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("aux_idle_mask_clear", obs_mask, 32'd0);

        // WAW: pipe to reg 3 waits behind queued aux reg 3.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAA);
        step(1'b1, 5'd3, 32'hBB, 1'b0, 5'd0, 32'd0);
        chk("waw_stall", 32'(obs_stall), 32'd1);
        chk("waw_first_aux", rf_write_data, 32'hAA);
        step(1'b1, 5'd3, 32'hBB, 1'b0, 5'd0, 32'd0);
        chk("waw_release", 32'(obs_stall), 32'd0);
        chk("waw_then_pipe", rf_write_data, 32'hBB);
        step(1'b1, 5'd4, 32'hCC, 1'b0, 5'd0, 32'd0);
        chk("waw_other_reg", 32'(obs_stall), 32'd0);

        // Starvation: aux reg 2 behind continuous pipe traffic to reg 9.
        step(1'b1, 5'd9, 32'h900, 1'b1, 5'd2, 32'h22);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 5'd9, 32'h900 + 32'(i), 1'b0, 5'd0, 32'd0);
            chk("starve_stall", 32'(obs_stall), 32'(i == 5));
        end

        // Full FIFO, then simultaneous push and pop.
        step(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'hA0);
        step(1'b1, 5'd9, 32'h2, 1'b1, 5'd11, 32'hB0);
        step(1'b1, 5'd9, 32'h3, 1'b1, 5'd12, 32'hC0);
        chk("full_not_ready", 32'(obs_rdy), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0);
        chk("pushpop_ready", 32'(obs_rdy), 32'd1);
        chk("pushpop_pop_11", 32'(rf_write_reg), 32'd11);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pushpop_mask", obs_mask, 32'h2000);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Register 0 requests are accepted but never write.
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        chk("zero_stall", 32'(obs_stall), 32'd0);
        chk("zero_ready", 32'(obs_rdy), 32'd1);
        chk("zero_no_write", 32'(rf_reg_write), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("zero_mask", obs_mask, 32'd0);

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the main pipeline writeback stage (pipe);
  - an auxiliary multi-cycle unit such as load-return or mul/div (aux).
- Drives the register file's regWrite / write_reg / write_data through a registered output stage.
- Buffers aux writes in a small FIFO and enforces write-after-write ordering.
- Exports a pending-write mask for hazard detection.

Parameters:
- AUX_DEPTH, 2: aux FIFO entries; power of 2, minimum 2.
- MAX_WAIT, 4: cycles the aux FIFO head may lose arbitration before it is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wr_en  in  1  pipeline requests a write this cycle.
- pipe_wr_reg  in  5  pipeline destination register.
- pipe_wr_data  in  32  pipeline write data.
- pipe_stall  out  1  combinational; pipeline write not accepted this cycle, hold the request.
- aux_valid  in  1  aux unit offers a write.
- aux_reg  in  5  aux destination register.
- aux_data  in  32  aux write data.
- aux_ready  out  1  aux write accepted when aux_valid && aux_ready.
- rf_reg_write  out  1  registered; drives the register file's regWrite.
- rf_write_reg  out  5  registered; register file write address.
- rf_write_data  out  32  registered; register file write data.
- pending_mask  out  32  bit r set while any queued aux entry targets register r.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied, wait counter cleared.
  - rf_reg_write, rf_write_reg, rf_write_data, pending_mask all 0.
  - aux_ready=0 while in reset, 1 after.
  - Reset mid-operation discards all queued writes; no partial write is issued.
- aux_ready = FIFO not full, computed from registered state. There is no pop-bypass: a full FIFO that pops this cycle still shows aux_ready=0.
- Aux handshake:
  - aux_valid && aux_ready && aux_reg!=0: push {aux_reg, aux_data} at the edge.
  - aux_reg==0: accepted, discarded, never enqueued.
  - An aux write is never granted in the cycle it arrives. Minimum latency is 2 edges from acceptance to rf_reg_write=1.
- Pipe request is "live" when pipe_wr_en && pipe_wr_reg!=0. pipe_wr_en with register 0 is accepted, produces no write, and never stalls.
- Arbitration, evaluated every cycle, in priority order:
  1. FIFO non-empty and wait_cnt>=MAX_WAIT: aux head wins; a live pipe request gets pipe_stall=1.
  2. Live pipe request with pending_mask[pipe_wr_reg]=1 (WAW hazard): pipe_stall=1; aux head wins.
  3. Live pipe request: pipe wins, pipe_stall=0.
  4. Otherwise, FIFO non-empty: aux head wins (pop).
  5. Otherwise no write: rf_reg_write=0 next cycle.
- Winner is registered into rf_* at the next edge: 1-cycle latency for a granted pipe write.
- wait_cnt:
  - increments, saturating at MAX_WAIT, each cycle the FIFO is non-empty and the head is not granted;
  - clears on every pop;
  - stays 0 while the FIFO is empty.
- pending_mask:
  - combinational OR of one-hot(reg) over valid FIFO entries;
  - duplicate entries for one register are allowed; the bit clears only when the last matching entry pops;
  - an entry already moved to the output stage is no longer pending. The ordering guarantee still holds because the output stage commits before any later grant.
- Simultaneous push and pop: allowed in the same cycle (non-full FIFO); occupancy is unchanged.
- Pointer wrap: modulo AUX_DEPTH, with a separate count register to tell full from empty.
- pipe_stall depends only on current inputs and registered state; no combinational loop through aux inputs.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32;
  - typedef rf_wr_req_t {reg_addr, data};
  - enum grant_t {GRANT_NONE, GRANT_PIPE, GRANT_AUX}.
- Sub-module aux_write_fifo:
  - parameterised depth;
  - push/pop/full/empty/head;
  - per-entry valid vector for building pending_mask.

Test Plan:
- Reset then idle: rst_n low mid-traffic clears everything → all outputs 0, aux_ready=1 one cycle after rst_n rises.
- Pipe only: pipe_wr_en=1, reg=5, data=0xDEADBEEF → next edge rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; pipe_stall=0.
- Aux idle path: aux push reg=7, data=0x11 with pipe idle → pending_mask=0x80 after 1 edge; rf write of reg 7 after 2 edges; mask back to 0.
- WAW: aux reg=3 queued, then pipe writes reg=3 → pipe_stall=1 until aux reg 3 pops; writes commit in order aux then pipe; no stall on pipe reg=4.
- Starvation: pipe live every cycle on reg 9, aux reg=2 queued → after MAX_WAIT=4 lost cycles aux wins, pipe_stall=1 for exactly that one cycle, wait_cnt clears.
- Full and zero-register cases:
  - 2 aux pushes with pipe busy → aux_ready=0; push and pop in the same cycle when not full keeps occupancy;
  - aux_reg=0 or pipe_wr_reg=0 → accepted, rf_reg_write stays 0.
